uart_rx_8n1: RTL and testbench

// - Synthesizable 8N1 UART receiver with a small elastic buffer on the core side.
// - Bytes sent on the line by the bench UART model (8 data bits, no parity, 1 stop) arrive on rx_i.
// - Received bytes are presented on a valid/ready read port for a peripheral or debug sink.
// - Flags framing errors and buffer overruns.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_fifo_buf.sv | 57 +++++
 rtl/uart_rx_8n1.sv | 134 +++++++++++++
 tb/tb_uart_rx_8n1.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the 8N1 UART receiver.
// Holds the FSM state encoding and the bit-period calculation.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  localparam int UART_DATA_BITS = 8;

  function automatic int clks_per_bit(
    input int freq,
    input int baud
  );
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_buf.sv
// First-word fall-through synchronous FIFO for received bytes.
// Drops pushes when full unless a pop frees a slot that same cycle.
module uart_rx_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign overrun = push && full && !do_pop;
  assign count   = cnt;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM and
// an elastic byte buffer with valid/ready read port.
module uart_rx_8n1
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int BAUD_RATE   = 781_250,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_i,
  input  logic                            rx_en_i,
  output logic [7:0]                      rdata_o,
  output logic                            rvalid_o,
  input  logic                            rready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
  output logic                            frame_err_o,
  output logic                            overrun_o,
  output logic                            busy_o
);

  localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB);
  localparam int BIT_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

  if (CPB < 4) begin : g_cpb_chk
    $error("CLKS_PER_BIT must be >= 4");
  end

  rx_state_e                 state;
  rx_state_e                 state_n;
  logic                      rx_meta;
  logic                      rx_s;
  logic [CNT_W-1:0]          cnt;
  logic [BIT_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      sample_data;
  logic                      push;
  logic                      frame_err;
  logic                      fifo_full;
  logic                      fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (rx_en_i && !rx_s) state_n = START;
      START:
        if (cnt == CNT_HALF) state_n = rx_s ? IDLE : DATA;
      DATA:
        if (cnt == CNT_LAST && bit_idx == BIT_LAST)
          state_n = STOP;
      STOP:
        if (cnt == CNT_LAST) state_n = rx_s ? IDLE : BREAK;
      BREAK:
        if (rx_s) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state != IDLE);
    sample_data = (state == DATA) && (cnt == CNT_LAST);
    push        = 1'b0;
    frame_err   = 1'b0;
    if (state == STOP && cnt == CNT_LAST) begin
      push      = rx_s;
      frame_err = !rx_s;
    end
  end

  // Counter restarts on every state change so each phase times from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state != state_n || state == IDLE || state == BREAK)
        cnt <= '0;
      else if (cnt == CNT_LAST)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state == START)
        bit_idx <= '0;
      else if (sample_data)
        bit_idx <= bit_idx + 1'b1;
      if (sample_data)
        shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
    end
  end

  assign frame_err_o = frame_err;
  assign rvalid_o    = !fifo_empty;

  uart_rx_fifo_buf #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wdata   (shreg),
    .pop     (rready_i),
    .rdata   (rdata_o),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count_o),
    .overrun (overrun_o)
  );

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1 driven by a line-level UART model.
// Expected bytes and flag counts come from a queue-based reference.
module tb_uart_rx_8n1;

  localparam int CPB   = 32;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       rx_en_i = 1'b1;
  logic       rready_i = 1'b0;
  logic [7:0] rdata_o;
  logic       rvalid_o;
  logic [3:0] count_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;
  logic [7:0] got[$];

  uart_rx_8n1 dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_i),
    .rx_en_i     (rx_en_i),
    .rdata_o     (rdata_o),
    .rvalid_o    (rvalid_o),
    .rready_i    (rready_i),
    .count_o     (count_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid_o && rready_i) got.push_back(rdata_o);
      if (frame_err_o) fe_cnt++;
      if (overrun_o) ov_cnt++;
      if (frame_err_o && overrun_o) both_cnt++;
    end
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick(CPB);
    end
    rx_i = stop;
    tick(CPB);
    rx_i = 1'b1;
  endtask

  task automatic wait_got(input int n, input int budget);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  task automatic test_reset;
    tick(3);
    tests++;
    if ({rvalid_o, count_o, busy_o} !== 6'b0) begin
      fails++;
      $display("FAIL reset_status: got %b want 000000",
               {rvalid_o, count_o, busy_o});
    end
    tests++;
    if ({frame_err_o, overrun_o, rdata_o} !== 10'h0) begin
      fails++;
      $display("FAIL reset_flags: got %h want 000",
               {frame_err_o, overrun_o, rdata_o});
    end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_latency;
    int lat;
    bit seen;
    logic [7:0] d;
    logic [3:0] c;
    lat = 0;
    seen = 0;
    d = 8'h00;
    c = 4'hF;
    rready_i = 1'b1;
    got.delete();
    fork
      send_byte(8'h65, 1'b1);
      begin
        for (int k = 0; k < 400 && !seen; k++) begin
          @(posedge clk);
          #1;
          lat++;
          if (rvalid_o) begin
            seen = 1;
            d = rdata_o;
          end
        end
        tick(1);
        c = count_o;
      end
    join
    tests++;
    if (lat !== 307) begin
      fails++;
      $display("FAIL latency: got %0d want 307", lat);
    end
    tests++;
    if (d !== 8'h65) begin
      fails++;
      $display("FAIL latency_data: got %h want 65", d);
    end
    tests++;
    if (c !== 4'd0) begin
      fails++;
      $display("FAIL latency_pop_count: got %0d want 0", c);
    end
    tests++;
    if (got.size() !== 1) begin
      fails++;
      $display("FAIL latency_pops: got %0d want 1", got.size());
    end
  endtask

  task automatic test_overrun;
    logic [7:0] model[$];
    int exp_ov;
    int ov0;
    exp_ov = 0;
    ov0 = ov_cnt;
    rready_i = 1'b0;
    got.delete();
    for (int b = 0; b < 10; b++) begin
      send_byte(8'(b), 1'b1);
      if (model.size() < 8) model.push_back(8'(b));
      else exp_ov++;
    end
    tick(20);
    tests++;
    if (count_o !== 4'd8) begin
      fails++;
      $display("FAIL overrun_count: got %0d want 8", count_o);
    end
    tests++;
    if (ov_cnt - ov0 !== exp_ov) begin
      fails++;
      $display("FAIL overrun_pulses: got %0d want %0d",
               ov_cnt - ov0, exp_ov);
    end
    rready_i = 1'b1;
    wait_got(8, 100);
    tick(5);
    tests++;
    if (got.size() !== model.size()) begin
      fails++;
      $display("FAIL drain_size: got %0d want %0d",
               got.size(), model.size());
    end
    for (int i = 0; i < got.size() && i < model.size(); i++) begin
      tests++;
      if (got[i] !== model[i]) begin
        fails++;
        $display("FAIL drain_byte%0d: got %h want %h",
                 i, got[i], model[i]);
      end
    end
    tests++;
    if (count_o !== 4'd0) begin
      fails++;
      $display("FAIL drain_count: got %0d want 0", count_o);
    end
  endtask

  task automatic test_frame_err;
    int fe0;
    fe0 = fe_cnt;
    rready_i = 1'b1;
    got.delete();
    send_byte(8'hA5, 1'b0);
    tick(64);
    tests++;
    if (fe_cnt - fe0 !== 1) begin
      fails++;
      $display("FAIL frame_err_pulses: got %0d want 1", fe_cnt - fe0);
    end
    tests++;
    if (got.size() !== 0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL frame_err_drop: got pops=%0d busy=%b want 0 0",
               got.size(), busy_o);
    end
  endtask

  task automatic test_break;
    int fe0;
    fe0 = fe_cnt;
    got.delete();
    rx_i = 1'b0;
    tick(3 * FRAME);
    rx_i = 1'b1;
    tick(2 * CPB);
    send_byte(8'h3C, 1'b1);
    wait_got(1, 100);
    tick(2);
    tests++;
    if (fe_cnt - fe0 !== 1) begin
      fails++;
      $display("FAIL break_err_pulses: got %0d want 1", fe_cnt - fe0);
    end
    tests++;
    if (got.size() !== 1 || got[0] !== 8'h3C) begin
      fails++;
      $display("FAIL break_byte: got n=%0d b=%h want n=1 b=3c",
               got.size(), got[0]);
    end
  endtask

  task automatic test_glitch;
    int fe0;
    int ov0;
    logic b_mid;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    got.delete();
    rx_i = 1'b0;
    tick(6);
    b_mid = busy_o;
    tick(7);
    rx_i = 1'b1;
    tick(CPB);
    tests++;
    if (b_mid !== 1'b1) begin
      fails++;
      $display("FAIL glitch_busy_mid: got %b want 1", b_mid);
    end
    tests++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL glitch_busy_end: got %b want 0", busy_o);
    end
    tests++;
    if (fe_cnt != fe0 || ov_cnt != ov0 || got.size() != 0) begin
      fails++;
      $display("FAIL glitch_quiet: got fe=%0d ov=%0d pops=%0d want 0",
               fe_cnt - fe0, ov_cnt - ov0, got.size());
    end
  endtask

  task automatic test_reset_mid;
    logic b_mid;
    rready_i = 1'b1;
    got.delete();
    rx_i = 1'b0;
    tick(CPB);
    rx_i = 1'b1;
    tick(3 * CPB);
    b_mid = busy_o;
    rst = 1'b1;
    tick(2);
    tests++;
    if (b_mid !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_busy_before: got %b want 1", b_mid);
    end
    tests++;
    if ({busy_o, rvalid_o, count_o} !== 6'b0) begin
      fails++;
      $display("FAIL rstmid_state: got %b want 000000",
               {busy_o, rvalid_o, count_o});
    end
    rst = 1'b0;
    tick(6 * CPB);
    tests++;
    if (got.size() !== 0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_nopush: got pops=%0d busy=%b want 0 0",
               got.size(), busy_o);
    end
    send_byte(8'h12, 1'b1);
    wait_got(1, 100);
    tick(2);
    tests++;
    if (got.size() !== 1 || got[0] !== 8'h12) begin
      fails++;
      $display("FAIL rstmid_byte: got n=%0d b=%h want n=1 b=12",
               got.size(), got[0]);
    end
  endtask

  task automatic test_rx_en;
    got.delete();
    rx_en_i = 1'b1;
    fork
      send_byte(8'h81, 1'b1);
      begin
        tick(3 * CPB);
        rx_en_i = 1'b0;
      end
    join
    send_byte(8'h5A, 1'b1);
    tick(CPB);
    tests++;
    if (got.size() !== 1 || got[0] !== 8'h81) begin
      fails++;
      $display("FAIL rx_en_bytes: got n=%0d b=%h want n=1 b=81",
               got.size(), got[0]);
    end
    tests++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL rx_en_busy: got %b want 0", busy_o);
    end
    rx_en_i = 1'b1;
    tick(CPB);
  endtask

  task automatic test_random;
    logic [7:0] sent[$];
    logic [7:0] b;
    bit done;
    done = 0;
    got.delete();
    fork
      begin
        for (int n = 0; n < 12; n++) begin
          b = 8'($urandom_range(0, 255));
          sent.push_back(b);
          send_byte(b, 1'b1);
          tick($urandom_range(0, 40));
        end
        done = 1;
      end
      begin
        while (!done) begin
          rready_i = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    rready_i = 1'b1;
    wait_got(12, 200);
    tick(2);
    tests++;
    if (got.size() !== sent.size()) begin
      fails++;
      $display("FAIL random_size: got %0d want %0d",
               got.size(), sent.size());
    end
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      tests++;
      if (got[i] !== sent[i]) begin
        fails++;
        $display("FAIL random_byte%0d: got %h want %h",
                 i, got[i], sent[i]);
      end
    end
    tests++;
    if (both_cnt !== 0) begin
      fails++;
      $display("FAIL flags_exclusive: got %0d want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overrun();
    test_frame_err();
    test_break();
    test_glitch();
    test_reset_mid();
    test_rx_en();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
